bcd_to_bin: RTL and testbench
=============================

// Module: bcd_to_bin
// PURPOSE
//  Converts the packed keypad digit word from the input stage (DIGITS x 4-bit,
//  MS digit in the top nibble) into an unsigned binary integer for the FP
//  packing stage. Sequential multiply-by-10-and-add, one digit per clock, with
//  a start/busy/done handshake. Flags non-decimal nibbles (keypad A-F, *, #)
//  and binary overflow.
// PARAMETERS
//  DIGITS  5   number of BCD digits in bcd_in
//  OUT_W   17  width of bin_out; 17 holds 99999 without overflow
// PORTS
//  clk      in   1           system clock, rising edge
//  reset    in   1           asynchronous, active-low reset
//  start    in   1           request conversion; sampled only in IDLE
//  bcd_in   in   DIGITS*4    packed digits; [DIGITS*4-1 -: 4] = MS digit
//  busy     out  1           high in CONV
//  done     out  1           one-cycle pulse: result/flags valid
//  bin_out  out  OUT_W       binary result; held until next start
//  err      out  1           non-decimal nibble seen; held until next start
//  ovf      out  1           result exceeded 2^OUT_W-1; held until next start
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; busy=0, done=0, bin_out=0, err=0,
//   ovf=0; shadow reg, accumulator and digit counter cleared. Reset mid-CONV
//   aborts; no done pulse.
//  States: IDLE -> CONV -> DONE -> IDLE.
//  IDLE: on edge with start=1: latch bcd_in into shadow, acc=0, cnt=0,
//   clear err/ovf, bin_out=0, go CONV. start=0: stay.
//  CONV (busy=1), per edge: d = shadow[top nibble].
//   d<=9: acc = acc*10 + d ((acc<<3)+(acc<<1)+d, computed in OUT_W+4 bits).
//   Any of the upper 4 bits set -> ovf=1 (sticky); acc keeps low OUT_W bits.
//   shadow <<= 4, cnt++. cnt==DIGITS-1 on this edge -> bin_out=new acc,
//   go DONE.
//   d>9: err=1, bin_out=0, ovf unchanged, go DONE immediately.
//  DONE: done=1 for exactly this cycle, busy=0; next edge -> IDLE.
//  Latency: start sampled at edge 0 -> done high in the cycle after edge
//   DIGITS (DIGITS+1 edges start-to-done incl. DONE). Error: done follows the
//   edge that sees the bad digit.
//  start while in CONV or DONE is ignored (no queueing). Changes on bcd_in
//   after the start edge do not affect the conversion.
//  Leading zeros are legal; all-zero input -> bin_out=0, err=0, ovf=0.
//  bin_out/err/ovf change only on start acceptance and completion; stable
//   otherwise.
// TESTING
//  bcd_in=0x12345, start 1 cycle -> busy 5 cycles, done pulse, bin_out=12345
//   (0x3039), err=0, ovf=0.
//  bcd_in=0x99999 -> bin_out=99999 (0x1869F); then 0x00000 -> bin_out=0.
//  bcd_in=0x12A45 -> done 3 edges after start, err=1, bin_out=0; next start
//   with 0x00042 -> err=0, bin_out=42.
//  start held high for 10 cycles, bcd_in changed mid-CONV -> exactly one
//   conversion of the latched value, one done pulse, next accepted in IDLE.
//  reset=0 during the 3rd CONV cycle -> all outputs 0 at once, no done; after
//   release, start with 0x00007 -> bin_out=7.
//  OUT_W=16, bcd_in=0x99999 -> ovf=1, bin_out=34463 (99999 mod 65536), err=0.

Source files
------------

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter: one digit per clock, MS digit first,
// with start/busy/done handshake plus non-decimal and overflow flags.
module bcd_to_bin #(
    parameter int DIGITS = 5,
    parameter int OUT_W  = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIGITS*4-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [OUT_W-1:0]      bin_out,
    output logic                  err,
    output logic                  ovf,
    output logic [1:0]            dbg_state
);

    // Handshake: start is sampled only in IDLE; busy is high for the whole
    // conversion; done is a one-cycle pulse when bin_out/err/ovf are valid.
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [DIGITS*4-1:0]   shadow, shadow_nxt;
    logic [OUT_W-1:0]      acc, acc_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [OUT_W-1:0]      bin_nxt;
    logic                  err_nxt, ovf_nxt;

    logic [3:0]            digit;
    logic [OUT_W+3:0]      acc_ext;
    logic [OUT_W+3:0]      wide;

    // acc*10 + d in four extra bits so any carry out of OUT_W is visible.
    assign digit   = shadow[DIGITS*4-1 -: 4];
    assign acc_ext = {4'b0000, acc};
    assign wide    = (acc_ext << 3) + (acc_ext << 1) + {{OUT_W{1'b0}}, digit};

    assign busy      = (state == CONV);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shadow  <= '0;
            acc     <= '0;
            cnt     <= '0;
            bin_out <= '0;
            err     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            shadow  <= shadow_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            bin_out <= bin_nxt;
            err     <= err_nxt;
            ovf     <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        bin_nxt    = bin_out;
        err_nxt    = err;
        ovf_nxt    = ovf;
        case (state)
            IDLE: begin
                if (start) begin
                    shadow_nxt = bcd_in;
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                    bin_nxt    = '0;
                    err_nxt    = 1'b0;
                    ovf_nxt    = 1'b0;
                    state_nxt  = CONV;
                end
            end
            CONV: begin
                if (digit > 4'd9) begin
                    err_nxt   = 1'b1;
                    bin_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    acc_nxt    = wide[OUT_W-1:0];
                    if (|wide[OUT_W+3:OUT_W]) begin
                        ovf_nxt = 1'b1;
                    end
                    shadow_nxt = shadow << 4;
                    cnt_nxt    = cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        bin_nxt   = wide[OUT_W-1:0];
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: a 17-bit instance and a 16-bit instance
// share stimulus so the overflow path can be checked alongside normal results.
module tb_bcd_to_bin;

    logic        clk;
    logic        reset;
    logic        start;
    logic [19:0] bcd_in;

    logic        busy, done, err, ovf;
    logic [16:0] bin_out;
    logic [1:0]  dbg_state;

    logic        busy16, done16, err16, ovf16;
    logic [15:0] bin16;
    logic [1:0]  dbg_state16;

    int checks;
    int failures;

    bcd_to_bin #(.DIGITS(5), .OUT_W(17)) dut (
        .clk(clk), .reset(reset), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .bin_out(bin_out), .err(err), .ovf(ovf),
        .dbg_state(dbg_state)
    );

    bcd_to_bin #(.DIGITS(5), .OUT_W(16)) dut16 (
        .clk(clk), .reset(reset), .start(start), .bcd_in(bcd_in),
        .busy(busy16), .done(done16), .bin_out(bin16), .err(err16), .ovf(ovf16),
        .dbg_state(dbg_state16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic run_conv(input logic [19:0] v, input int exp_busy,
                            input logic [16:0] eb, input logic ee, input logic eo,
                            input logic [15:0] eb16, input logic eo16);
        int n;
        @(negedge clk);
        start  = 1'b1;
        bcd_in = v;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("busy_cycles_%05h", v), n, exp_busy);
        check($sformatf("done_%05h", v), {31'd0, done}, 32'd1);
        check($sformatf("done16_%05h", v), {31'd0, done16}, 32'd1);
        check($sformatf("bin_%05h", v), {15'd0, bin_out}, {15'd0, eb});
        check($sformatf("err_%05h", v), {31'd0, err}, {31'd0, ee});
        check($sformatf("ovf_%05h", v), {31'd0, ovf}, {31'd0, eo});
        check($sformatf("bin16_%05h", v), {16'd0, bin16}, {16'd0, eb16});
        check($sformatf("err16_%05h", v), {31'd0, err16}, {31'd0, ee});
        check($sformatf("ovf16_%05h", v), {31'd0, ovf16}, {31'd0, eo16});
        @(negedge clk);
        check($sformatf("done_pulse_end_%05h", v), {31'd0, done}, 32'd0);
        check($sformatf("bin_held_%05h", v), {15'd0, bin_out}, {15'd0, eb});
    endtask

    initial begin
        int dones;
        int n;
        logic [16:0] bin_at_done;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        start    = 1'b0;
        bcd_in   = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bin", {15'd0, bin_out}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_state16", {30'd0, dbg_state16}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_no_start", {31'd0, busy}, 32'd0);

        run_conv(20'h12345, 5, 17'd12345, 1'b0, 1'b0, 16'd12345, 1'b0);
        run_conv(20'h99999, 5, 17'd99999, 1'b0, 1'b0, 16'd34463, 1'b1);
        run_conv(20'h00000, 5, 17'd0,     1'b0, 1'b0, 16'd0,     1'b0);
        run_conv(20'h12A45, 3, 17'd0,     1'b1, 1'b0, 16'd0,     1'b0);
        run_conv(20'h00042, 5, 17'd42,    1'b0, 1'b0, 16'd42,    1'b0);
        run_conv(20'h0000F, 5, 17'd0,     1'b1, 1'b0, 16'd0,     1'b0);

        // start held for ten edges; bcd_in changes right after acceptance.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 20'h00314;
        dones = 0;
        bin_at_done = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) bcd_in = 20'h55555;
            if (done) begin
                dones++;
                bin_at_done = bin_out;
            end
            if (i == 6) begin
                check("held_idle_busy", {31'd0, busy}, 32'd0);
                check("held_idle_bin", {15'd0, bin_out}, 32'd314);
            end
            if (i == 7) begin
                check("held_reaccept_busy", {31'd0, busy}, 32'd1);
                check("held_reaccept_bin_clr", {15'd0, bin_out}, 32'd0);
            end
        end
        start = 1'b0;
        check("held_done_count", dones, 1);
        check("held_latched_bin", {15'd0, bin_at_done}, 32'd314);
        n = 0;
        while (!done && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("held_second_done", {31'd0, done}, 32'd1);
        check("held_second_bin", {15'd0, bin_out}, 32'd55555);
        check("held_second_bin16", {16'd0, bin16}, 32'd55555);
        @(negedge clk);

        // Asynchronous reset during the third CONV cycle.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 20'h12345;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_bin", {15'd0, bin_out}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        check("midrst_ovf", {31'd0, ovf}, 32'd0);
        check("midrst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_no_done", dones, 0);
        run_conv(20'h00007, 5, 17'd7, 1'b0, 1'b0, 16'd7, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
